// File: rtl/rom_vector_sequencer.sv
// ---------------------------------------------------------------------------
// rom_vector_sequencer
//
// Walks the 128-bit test-vector ROM and streams each selected vector to the
// byte-serial AES cipher input, MSB byte first (rom_address 0 = bits 127:120).
// A run covers vectors first_index..last_index inclusive. The depth counter
// wraps modulo 2**DEPTH_W, so last_index < first_index is a legal run.
// After each vector the sequencer can wait for the cipher's blk_done pulse
// (WAIT_DONE) and/or idle for GAP_CYCLES cycles before the next vector.
//
// Parameters
//   DEPTH_W    width of the vector index (ROM holds 2**DEPTH_W vectors)
//   WAIT_DONE  1: wait for blk_done after each vector's last byte
//   GAP_CYCLES idle cycles between vectors (0..255)
//
// Optional build macro
//   ROM_SEQ_LOOP_EN  adds input loop_en. When loop_en is high at the
//                    decision point on last_index, the run restarts at
//                    first_index. done pulses once per pass.
//
// Ports
//   clk                rising-edge clock
//   rst                asynchronous active-low reset
//   start              one-cycle pulse; accepted only when idle
//   first_index        first vector index, sampled on accepted start
//   last_index         last vector index (inclusive), sampled on start
//   rom_address        byte select to the ROM
//   rom_address_depth  vector select to the ROM
//   rom_data           combinational ROM byte for the current address
//   byte_out           streamed byte (combinational pass of rom_data)
//   byte_valid         byte_out valid
//   byte_ready         downstream accepts the byte when valid && ready
//   byte_last          high with byte 15 of each vector
//   blk_done           cipher block-done pulse
//   busy               high in every state except IDLE
//   done               one-cycle pulse after the final vector
//   vec_count          vectors fully sent in the current run
// ---------------------------------------------------------------------------
module rom_vector_sequencer #(
    parameter int DEPTH_W    = 9,
    parameter bit WAIT_DONE  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DEPTH_W-1:0] first_index,
    input  logic [DEPTH_W-1:0] last_index,
`ifdef ROM_SEQ_LOOP_EN
    input  logic               loop_en,
`endif
    output logic [3:0]         rom_address,
    output logic [DEPTH_W-1:0] rom_address_depth,
    input  logic [7:0]         rom_data,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               byte_last,
    input  logic               blk_done,
    output logic               busy,
    output logic               done,
    output logic [DEPTH_W:0]   vec_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_BLK = 3'd2,
        S_GAP      = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    // Terminal count of the gap counter; the GAP state lasts GAP_CYCLES cycles.
    localparam logic [7:0] GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t             state_q;
    state_t             state_d;
    logic [DEPTH_W-1:0] last_q;
`ifdef ROM_SEQ_LOOP_EN
    logic [DEPTH_W-1:0] first_q;
`endif
    logic [7:0]         gap_cnt;
    logic               done_q;

    logic               hs;
    logic               final_byte;
    logic               at_last;
    logic               wrap_run;
    logic               decide;

    // Outputs are decoded straight from the state register so that an
    // asynchronous reset drops byte_valid immediately.
    assign byte_valid = (state_q == S_SEND);
    assign byte_out   = rom_data;
    assign final_byte = (rom_address == 4'hF);
    assign byte_last  = byte_valid && final_byte;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

    assign hs         = byte_valid && byte_ready;
    assign at_last    = (rom_address_depth == last_q);

`ifdef ROM_SEQ_LOOP_EN
    assign wrap_run   = loop_en && at_last;
`else
    assign wrap_run   = 1'b0;
`endif

    // ---- state register -----------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ---------------------------------------------------
    // 'decide' marks the cycle in which the current vector is complete and
    // the sequencer chooses between the next vector and the end of the run.
    always_comb begin
        state_d = state_q;
        decide  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (hs && final_byte) begin
                    if (WAIT_DONE) begin
                        state_d = S_WAIT_BLK;
                    end else if (HAS_GAP) begin
                        state_d = S_GAP;
                    end else begin
                        decide = 1'b1;
                    end
                end
            end
            S_WAIT_BLK: begin
                if (blk_done) begin
                    if (HAS_GAP) begin
                        state_d = S_GAP;
                    end else begin
                        decide = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    decide = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (decide) begin
            state_d = (at_last && !wrap_run) ? S_FINISH : S_SEND;
        end
    end

    // ---- address, counters and run bounds -----------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_address       <= 4'd0;
            rom_address_depth <= '0;
            last_q            <= '0;
`ifdef ROM_SEQ_LOOP_EN
            first_q           <= '0;
`endif
            vec_count         <= '0;
            gap_cnt           <= 8'd0;
            done_q            <= 1'b0;
        end else begin
            // done fires once per completed pass, whether the run ends or loops.
            done_q <= decide && at_last;

            // Counter is held at zero outside GAP so every gap starts fresh.
            if (state_q == S_GAP) begin
                gap_cnt <= gap_cnt + 8'd1;
            end else begin
                gap_cnt <= 8'd0;
            end

            if ((state_q == S_IDLE) && start) begin
                last_q            <= last_index;
`ifdef ROM_SEQ_LOOP_EN
                first_q           <= first_index;
`endif
                rom_address_depth <= first_index;
                rom_address       <= 4'd0;
                vec_count         <= '0;
            end

            // Byte 15 wraps the byte select back to 0 for the next vector.
            if (hs) begin
                rom_address <= rom_address + 4'd1;
                if (final_byte) begin
                    vec_count <= vec_count + (DEPTH_W+1)'(1);
                end
            end

            // Depth advances modulo 2**DEPTH_W; it holds on the final vector.
            if (decide && (state_d == S_SEND)) begin
`ifdef ROM_SEQ_LOOP_EN
                if (wrap_run) begin
                    rom_address_depth <= first_q;
                end else begin
                    rom_address_depth <= rom_address_depth + DEPTH_W'(1);
                end
`else
                rom_address_depth <= rom_address_depth + DEPTH_W'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_rom_vector_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for rom_vector_sequencer.
// Three instances cover the parameter corners:
//   dut0: WAIT_DONE=0, GAP_CYCLES=0 (back-to-back streaming)
//   dut1: WAIT_DONE=1, GAP_CYCLES=0 (waits for blk_done)
//   dut2: WAIT_DONE=0, GAP_CYCLES=3 (idle gap between vectors)
// Each instance has its own ROM model; a selector routes one instance's
// outputs to the m_* observation signals used by the test tasks.
// ---------------------------------------------------------------------------
module tb_rom_vector_sequencer;

    localparam int DW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          byte_ready;
    logic          blk_done;
    logic          loop_en;
    logic [DW-1:0] first_index;
    logic [DW-1:0] last_index;
    logic          start0, start1, start2;

    logic [3:0]    addr0, addr1, addr2;
    logic [DW-1:0] dep0, dep1, dep2;
    logic [7:0]    rd0, rd1, rd2;
    logic [7:0]    bo0, bo1, bo2;
    logic          bv0, bv1, bv2;
    logic          bl0, bl1, bl2;
    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;
    logic [DW:0]   vc0, vc1, vc2;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    // ROM contents: distinct byte per address within a vector.
    function automatic logic [7:0] rom_byte(input logic [DW-1:0] v, input logic [3:0] a);
        logic [7:0] t;
        t = {a, 4'h0} + v[7:0] * 8'd37 + {v[8], 7'd0};
        return t ^ 8'hA5;
    endfunction

    assign rd0 = rom_byte(dep0, addr0);
    assign rd1 = rom_byte(dep1, addr1);
    assign rd2 = rom_byte(dep2, addr2);

    rom_vector_sequencer #(.DEPTH_W(DW), .WAIT_DONE(1'b0), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .first_index(first_index), .last_index(last_index),
`ifdef ROM_SEQ_LOOP_EN
        .loop_en(loop_en),
`endif
        .rom_address(addr0), .rom_address_depth(dep0), .rom_data(rd0),
        .byte_out(bo0), .byte_valid(bv0), .byte_ready(byte_ready), .byte_last(bl0),
        .blk_done(blk_done), .busy(busy0), .done(done0), .vec_count(vc0)
    );

    rom_vector_sequencer #(.DEPTH_W(DW), .WAIT_DONE(1'b1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .first_index(first_index), .last_index(last_index),
`ifdef ROM_SEQ_LOOP_EN
        .loop_en(loop_en),
`endif
        .rom_address(addr1), .rom_address_depth(dep1), .rom_data(rd1),
        .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready), .byte_last(bl1),
        .blk_done(blk_done), .busy(busy1), .done(done1), .vec_count(vc1)
    );

    rom_vector_sequencer #(.DEPTH_W(DW), .WAIT_DONE(1'b0), .GAP_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .first_index(first_index), .last_index(last_index),
`ifdef ROM_SEQ_LOOP_EN
        .loop_en(loop_en),
`endif
        .rom_address(addr2), .rom_address_depth(dep2), .rom_data(rd2),
        .byte_out(bo2), .byte_valid(bv2), .byte_ready(byte_ready), .byte_last(bl2),
        .blk_done(blk_done), .busy(busy2), .done(done2), .vec_count(vc2)
    );

    logic          m_valid, m_last, m_busy, m_done;
    logic [7:0]    m_byte;
    logic [3:0]    m_addr;
    logic [DW-1:0] m_dep;
    logic [DW:0]   m_vc;

    always_comb begin
        m_valid = bv0; m_last = bl0; m_busy = busy0; m_done = done0;
        m_byte  = bo0; m_addr = addr0; m_dep = dep0; m_vc = vc0;
        if (sel == 1) begin
            m_valid = bv1; m_last = bl1; m_busy = busy1; m_done = done1;
            m_byte  = bo1; m_addr = addr1; m_dep = dep1; m_vc = vc1;
        end else if (sel == 2) begin
            m_valid = bv2; m_last = bl2; m_busy = busy2; m_done = done2;
            m_byte  = bo2; m_addr = addr2; m_dep = dep2; m_vc = vc2;
        end
    end

    // Pulses start on the selected instance. Returns at the falling edge of
    // the first SEND cycle, with byte 0 on the bus.
    task automatic start_run(input int s, input int f, input int l);
        @(negedge clk);
        sel         = s;
        first_index = DW'(f);
        last_index  = DW'(l);
        start0      = (s == 0);
        start1      = (s == 1);
        start2      = (s == 2);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({m_valid, m_last, m_busy, m_done, m_addr, m_dep, m_vc} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got v=%b l=%b busy=%b done=%b addr=%h dep=%h vc=%h required all zero",
                         s, m_valid, m_last, m_busy, m_done, m_addr, m_dep, m_vc);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_vector();
        byte_ready = 1'b1;
        start_run(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({m_valid, m_last, m_byte} !== {1'b1, (i == 15), rom_byte(9'd0, 4'(i))}) begin
                errors++;
                $display("FAIL single_byte[%0d]: got v/l/byte=%b/%b/%h required 1/%b/%h",
                         i, m_valid, m_last, m_byte, (i == 15), rom_byte(9'd0, 4'(i)));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({m_done, m_busy, m_valid, m_vc} !== {1'b1, 1'b1, 1'b0, 10'd1}) begin
            errors++;
            $display("FAIL single_done: got done=%b busy=%b valid=%b vc=%0d required 1 1 0 1",
                     m_done, m_busy, m_valid, m_vc);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({m_done, m_busy, m_vc} !== {1'b0, 1'b0, 10'd1}) begin
            errors++;
            $display("FAIL single_idle: got done=%b busy=%b vc=%0d required 0 0 1", m_done, m_busy, m_vc);
        end
    endtask

    task automatic test_ready_toggle();
        int         k = 0;
        int         cyc = 0;
        bit         hold = 1'b0;
        bit         seen_done = 1'b0;
        logic [7:0] hb = 8'h00;
        start_run(0, 3, 5);
        while (!seen_done && cyc < 300) begin
            byte_ready = (cyc % 2 == 0);
            #1;
            if (hold) begin
                checks++;
                if ({m_valid, m_byte} !== {1'b1, hb}) begin
                    errors++;
                    $display("FAIL toggle_stable cyc%0d: got v=%b byte=%h required 1 %h", cyc, m_valid, m_byte, hb);
                end
            end
            hold = 1'b0;
            if (m_done) begin
                seen_done = 1'b1;
            end else if (m_valid) begin
                if (byte_ready) begin
                    checks++;
                    if ({m_last, m_byte} !== {(k % 16 == 15), rom_byte(9'(3 + k / 16), 4'(k % 16))}) begin
                        errors++;
                        $display("FAIL toggle_byte[%0d]: got l/byte=%b/%h required %b/%h", k, m_last, m_byte,
                                 (k % 16 == 15), rom_byte(9'(3 + k / 16), 4'(k % 16)));
                    end
                    k++;
                end else begin
                    hold = 1'b1;
                    hb   = m_byte;
                end
            end
            cyc++;
            @(negedge clk);
        end
        byte_ready = 1'b1;
        #1;
        checks++;
        if (!seen_done || k != 48 || m_vc !== 10'd3) begin
            errors++;
            $display("FAIL toggle_total: got done_seen=%b bytes=%0d vc=%0d required 1 48 3", seen_done, k, m_vc);
        end
    endtask

    task automatic test_wait_done();
        byte_ready = 1'b1;
        start_run(1, 7, 8);
        for (int i = 0; i < 16; i++) begin
            blk_done = (i == 5);
            #1;
            checks++;
            if ({m_valid, m_dep, m_byte} !== {1'b1, 9'd7, rom_byte(9'd7, 4'(i))}) begin
                errors++;
                $display("FAIL wait_vec7[%0d]: got v/dep/byte=%b/%0d/%h required 1/7/%h",
                         i, m_valid, m_dep, m_byte, rom_byte(9'd7, 4'(i)));
            end
            @(negedge clk);
        end
        blk_done = 1'b0;
        for (int j = 0; j < 20; j++) begin
            #1;
            checks++;
            if ({m_valid, m_busy, m_dep, m_vc} !== {1'b0, 1'b1, 9'd7, 10'd1}) begin
                errors++;
                $display("FAIL wait_idle[%0d]: got v=%b busy=%b dep=%0d vc=%0d required 0 1 7 1",
                         j, m_valid, m_busy, m_dep, m_vc);
            end
            @(negedge clk);
        end
        blk_done = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_pulse_cycle: got valid=%b required 0", m_valid);
        end
        @(negedge clk);
        blk_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({m_valid, m_dep, m_byte} !== {1'b1, 9'd8, rom_byte(9'd8, 4'(i))}) begin
                errors++;
                $display("FAIL wait_vec8[%0d]: got v/dep/byte=%b/%0d/%h required 1/8/%h",
                         i, m_valid, m_dep, m_byte, rom_byte(9'd8, 4'(i)));
            end
            @(negedge clk);
        end
        repeat (3) begin
            #1;
            checks++;
            if ({m_valid, m_done} !== 2'b00) begin
                errors++;
                $display("FAIL wait_final_idle: got valid=%b done=%b required 0 0", m_valid, m_done);
            end
            @(negedge clk);
        end
        blk_done = 1'b1;
        #1;
        checks++;
        if (m_done !== 1'b0) begin
            errors++;
            $display("FAIL wait_early_done: got done=%b required 0", m_done);
        end
        @(negedge clk);
        blk_done = 1'b0;
        #1;
        checks++;
        if ({m_done, m_vc} !== {1'b1, 10'd2}) begin
            errors++;
            $display("FAIL wait_done: got done=%b vc=%0d required 1 2", m_done, m_vc);
        end
        @(negedge clk);
    endtask

    task automatic test_depth_wrap();
        byte_ready = 1'b1;
        start_run(0, 510, 1);
        for (int k = 0; k < 64; k++) begin
            #1;
            checks++;
            if ({m_valid, m_last, m_dep, m_byte} !==
                {1'b1, (k % 16 == 15), 9'(510 + k / 16), rom_byte(9'(510 + k / 16), 4'(k % 16))}) begin
                errors++;
                $display("FAIL wrap_byte[%0d]: got v/l/dep/byte=%b/%b/%0d/%h required 1/%b/%0d/%h",
                         k, m_valid, m_last, m_dep, m_byte, (k % 16 == 15), 9'(510 + k / 16),
                         rom_byte(9'(510 + k / 16), 4'(k % 16)));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({m_done, m_vc} !== {1'b1, 10'd4}) begin
            errors++;
            $display("FAIL wrap_done: got done=%b vc=%0d required 1 4", m_done, m_vc);
        end
        @(negedge clk);
    endtask

    task automatic test_gap();
        byte_ready = 1'b1;
        start_run(2, 20, 21);
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 16; i++) begin
                #1;
                checks++;
                if ({m_valid, m_last, m_byte} !== {1'b1, (i == 15), rom_byte(9'(20 + v), 4'(i))}) begin
                    errors++;
                    $display("FAIL gap_byte v%0d[%0d]: got v/l/byte=%b/%b/%h required 1/%b/%h",
                             v, i, m_valid, m_last, m_byte, (i == 15), rom_byte(9'(20 + v), 4'(i)));
                end
                @(negedge clk);
            end
            for (int g = 0; g < 3; g++) begin
                #1;
                checks++;
                if ({m_valid, m_busy, m_done} !== 3'b010) begin
                    errors++;
                    $display("FAIL gap_idle v%0d[%0d]: got valid=%b busy=%b done=%b required 0 1 0",
                             v, g, m_valid, m_busy, m_done);
                end
                @(negedge clk);
            end
        end
        #1;
        checks++;
        if ({m_done, m_vc} !== {1'b1, 10'd2}) begin
            errors++;
            $display("FAIL gap_done: got done=%b vc=%0d required 1 2", m_done, m_vc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        byte_ready = 1'b1;
        start_run(0, 40, 41);
        for (int i = 0; i < 8; i++) begin
            // A start while busy must not relatch the run bounds.
            start0 = (i == 3);
            if (i == 3) begin
                first_index = 9'd100;
                last_index  = 9'd100;
            end
            #1;
            checks++;
            if ({m_valid, m_dep, m_byte} !== {1'b1, 9'd40, rom_byte(9'd40, 4'(i))}) begin
                errors++;
                $display("FAIL mid_byte[%0d]: got v/dep/byte=%b/%0d/%h required 1/40/%h",
                         i, m_valid, m_dep, m_byte, rom_byte(9'd40, 4'(i)));
            end
            if (i < 7) @(negedge clk);
        end
        start0 = 1'b0;
        rst    = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, m_busy, m_done, m_addr, m_dep, m_vc} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b l=%b busy=%b done=%b addr=%h dep=%0d vc=%0d required all zero",
                     m_valid, m_last, m_busy, m_done, m_addr, m_dep, m_vc);
        end
        @(negedge clk);
        rst = 1'b1;
        start_run(0, 40, 41);
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++;
            if ({m_valid, m_byte} !== {1'b1, rom_byte(9'(40 + k / 16), 4'(k % 16))}) begin
                errors++;
                $display("FAIL replay_byte[%0d]: got v/byte=%b/%h required 1/%h",
                         k, m_valid, m_byte, rom_byte(9'(40 + k / 16), 4'(k % 16)));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({m_done, m_vc} !== {1'b1, 10'd2}) begin
            errors++;
            $display("FAIL replay_done: got done=%b vc=%0d required 1 2", m_done, m_vc);
        end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        byte_ready  = 1'b1;
        blk_done    = 1'b0;
        loop_en     = 1'b0;
        first_index = '0;
        last_index  = '0;
        start0      = 1'b0;
        start1      = 1'b0;
        start2      = 1'b0;

        test_reset();
        test_single_vector();
        test_ready_toggle();
        test_wait_done();
        test_depth_wrap();
        test_gap();
        test_reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rom_vector_sequencer.md
Name: rom_vector_sequencer

Overview:
Controller that walks the 128-bit test-vector ROM, selecting a vector via rom_address_depth and a byte via rom_address, and streams each vector MSB-byte-first to the byte-serial AES cipher input. Uses a valid/ready handshake on the byte stream. Optionally waits for the cipher's block-done pulse before starting the next vector. Sits between the vector ROM and the top cipher in the test/bring-up datapath.

Parameters:
DEPTH_W, 9, width of vector index; ROM holds 2**DEPTH_W vectors
WAIT_DONE, 1, 1 = wait for blk_done after each vector's last byte; 0 = go straight to next vector
GAP_CYCLES, 0, idle cycles inserted between vectors (0..255), counted after blk_done (or after last byte if WAIT_DONE=0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when IDLE, ignored otherwise
first_index  in  DEPTH_W  first vector index, sampled on accepted start
last_index  in  DEPTH_W  last vector index (inclusive), sampled on accepted start
rom_address  out  4  byte select to ROM (0 = bits 127:120)
rom_address_depth  out  DEPTH_W  vector select to ROM
rom_data  in  8  combinational ROM byte for current address/depth
byte_out  out  8  streamed byte (combinational pass of rom_data)
byte_valid  out  1  byte_out valid
byte_ready  in  1  downstream accepts byte when byte_valid && byte_ready
byte_last  out  1  high with byte 15 of each vector
blk_done  in  1  cipher finished current block (pulse)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after final vector completes
vec_count  out  DEPTH_W+1  vectors fully sent in current run

Behaviour:
- Reset (rst=0, async): state IDLE; rom_address=0; rom_address_depth=0; byte_valid=0; byte_last=0; busy=0; done=0; vec_count=0; gap counter=0.
- States: IDLE, SEND, WAIT_BLK, GAP, FINISH.
- IDLE: on start -> latch first/last; rom_address_depth=first_index; rom_address=0; vec_count=0; -> SEND next cycle.
- SEND: byte_valid=1; byte_out=rom_data (ROM combinational, zero latency); byte_last=(rom_address==15). On handshake: rom_address+1. Handshake with rom_address==15: rom_address wraps to 0, vec_count+1, -> WAIT_BLK if WAIT_DONE, else GAP if GAP_CYCLES>0, else next-vector decision. No handshake: all outputs held stable (valid must not drop).
- WAIT_BLK: byte_valid=0; wait for blk_done; blk_done seen in SEND or IDLE is ignored.
- GAP: count GAP_CYCLES cycles with byte_valid=0, then next-vector decision.
- Next-vector decision: if rom_address_depth==last_index -> FINISH; else rom_address_depth+1 -> SEND.
- FINISH: done=1 for exactly one cycle, busy=0 from the next cycle, -> IDLE. vec_count holds until the next start.
- last_index < first_index: depth counter wraps modulo 2**DEPTH_W until it equals last_index. first_index==last_index: exactly one vector.
- start while busy: ignored, no effect on counters.
- Reset mid-run: immediate return to reset values; byte_valid drops asynchronously.
- Throughput with WAIT_DONE=0, GAP_CYCLES=0, ready held high: 16 bytes per vector in 16 cycles, back-to-back.

Optional Feature:
ROM_SEQ_LOOP_EN: when defined, adds input loop_en (1 bit). If loop_en=1 at the next-vector decision on last_index, depth reloads first_index and the run continues. done pulses each pass; vec_count wraps at its width. A run with loop_en=1 ends only when loop_en is low at the decision point or on reset. Without the macro: no loop_en port, and every run ends after last_index.

Test Plan:
- Reset, then start with first=0, last=0, ready=1, WAIT_DONE=0 -> 16 bytes equal to ROM[0][127:120]..[7:0], byte_last on the 16th, done 1 cycle later, vec_count=1.
- first=3, last=5, ready toggling 1/0 each cycle -> 48 bytes in order; byte_out/valid stable while ready=0; vec_count=3.
- WAIT_DONE=1, blk_done delayed 20 cycles -> byte_valid=0 for those cycles; depth advances only after blk_done; spurious blk_done during SEND has no effect.
- first=510, last=1 (DEPTH_W=9) -> vectors 510, 511, 0, 1 sent; vec_count=4.
- GAP_CYCLES=3 -> exactly 3 valid-low cycles between byte_last handshake and the next vector's first byte.
- rst low mid-vector (byte 7) -> outputs at reset values immediately; a new start replays from byte 0 of first_index.
